// File: rtl/sys_irq_ctrl.sv
// Machine-mode interrupt controller: CSR file, 64-bit timer and the drain/enter
// handshake that turns an enabled pending interrupt into a one-cycle fetch redirect.
module sys_irq_ctrl #(
    parameter int XLEN     = 32,
    parameter int TICK_DIV = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_wr_vld,
    input  logic [11:0]     csr_wr_addr,
    input  logic [XLEN-1:0] csr_wr_data,
    input  logic [11:0]     csr_rd_addr,
    output logic [XLEN-1:0] csr_rd_data,
    input  logic            ext_irq,
    input  logic            sw_irq,
    input  logic            mret_vld,
    input  logic [XLEN-1:0] retire_pc,
    output logic            hold_req,
    input  logic            hold_ack,
    output logic            trap_vld,
    output logic [XLEN-1:0] trap_pc
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MTCMP_LO = 12'h7C0;
    localparam logic [11:0] ADDR_MTCMP_HI = 12'h7C1;
    localparam logic [11:0] ADDR_MTIME_LO = 12'hC01;
    localparam logic [11:0] ADDR_MTIME_HI = 12'hC81;

    localparam logic [XLEN-1:0] MIE_MASK   = XLEN'(32'h0000_0888);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_ENTER
    } state_t;

    state_t          state_reg;
    logic            hold_req_reg;
    logic            trap_vld_reg;
    logic            mie_bit_reg;
    logic            mpie_bit_reg;
    logic [XLEN-1:0] mie_reg;
    logic [XLEN-1:0] mtvec_reg;
    logic [XLEN-1:0] mepc_reg;
    logic [XLEN-1:0] mcause_reg;
    logic [63:0]     mtime_reg;
    logic [63:0]     mtimecmp_reg;
    logic [PW-1:0]   presc_reg;

    logic            mtip;
    logic [XLEN-1:0] mip_vec;
    logic [XLEN-1:0] pending;
    logic            take;
    logic [3:0]      cause;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] rd_next;
    logic            in_enter;

    logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_cmp_lo, wr_cmp_hi;

    assign mtip = (mtime_reg >= mtimecmp_reg);

    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_mip
            if (gi == 3) begin : g_msip
                assign mip_vec[gi] = sw_irq;
            end else if (gi == 7) begin : g_mtip
                assign mip_vec[gi] = mtip;
            end else if (gi == 11) begin : g_meip
                assign mip_vec[gi] = ext_irq;
            end else begin : g_zero
                assign mip_vec[gi] = 1'b0;
            end
        end
    endgenerate

    assign pending  = mip_vec & mie_reg;
    assign take     = mie_bit_reg & (|pending);
    assign in_enter = (state_reg == ST_ENTER);

    // Later assignments override earlier ones, so the last line checked wins: MEI > MSI > MTI.
    always_comb begin
        cause = 4'd0;
        if (pending[7]) begin
            cause = 4'd7;
        end
        if (pending[3]) begin
            cause = 4'd3;
        end
        if (pending[11]) begin
            cause = 4'd11;
        end
    end

    assign trap_base   = mtvec_reg & ALIGN_MASK;
    assign trap_target = (mtvec_reg[1:0] == 2'b01) ? (trap_base + XLEN'({cause, 2'b00}))
                                                   : trap_base;

    assign hold_req = hold_req_reg;
    assign trap_vld = trap_vld_reg;
    assign trap_pc  = trap_vld_reg ? trap_target : '0;

    assign wr_mstatus = csr_wr_vld && (csr_wr_addr == ADDR_MSTATUS);
    assign wr_mie     = csr_wr_vld && (csr_wr_addr == ADDR_MIE);
    assign wr_mtvec   = csr_wr_vld && (csr_wr_addr == ADDR_MTVEC);
    assign wr_mepc    = csr_wr_vld && (csr_wr_addr == ADDR_MEPC);
    assign wr_mcause  = csr_wr_vld && (csr_wr_addr == ADDR_MCAUSE);
    assign wr_cmp_lo  = csr_wr_vld && (csr_wr_addr == ADDR_MTCMP_LO);
    assign wr_cmp_hi  = csr_wr_vld && (csr_wr_addr == ADDR_MTCMP_HI);

    always_comb begin
        rd_next = '0;
        case (csr_rd_addr)
            ADDR_MSTATUS: begin
                rd_next[3] = mie_bit_reg;
                rd_next[7] = mpie_bit_reg;
            end
            ADDR_MIE:      rd_next = mie_reg;
            ADDR_MTVEC:    rd_next = mtvec_reg;
            ADDR_MEPC:     rd_next = mepc_reg;
            ADDR_MCAUSE:   rd_next = mcause_reg;
            ADDR_MIP:      rd_next = mip_vec;
            ADDR_MTCMP_LO: rd_next = XLEN'(mtimecmp_reg[31:0]);
            ADDR_MTCMP_HI: rd_next = XLEN'(mtimecmp_reg[63:32]);
            ADDR_MTIME_LO: rd_next = XLEN'(mtime_reg[31:0]);
            ADDR_MTIME_HI: rd_next = XLEN'(mtime_reg[63:32]);
            default:       rd_next = '0;
        endcase
    end

    assign csr_rd_data = rd_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            hold_req_reg <= 1'b0;
            trap_vld_reg <= 1'b0;
            mie_bit_reg  <= 1'b0;
            mpie_bit_reg <= 1'b0;
            mie_reg      <= '0;
            mtvec_reg    <= '0;
            mepc_reg     <= '0;
            mcause_reg   <= '0;
            mtime_reg    <= '0;
            mtimecmp_reg <= '1;
            presc_reg    <= '0;
        end else begin
            if (presc_reg == PRESC_LAST) begin
                presc_reg <= '0;
                mtime_reg <= mtime_reg + 64'd1;
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end

            if (wr_mie) begin
                mie_reg <= csr_wr_data & MIE_MASK;
            end
            if (wr_mtvec) begin
                mtvec_reg <= csr_wr_data;
            end
            if (wr_cmp_lo) begin
                mtimecmp_reg[31:0] <= csr_wr_data[31:0];
            end
            if (wr_cmp_hi) begin
                mtimecmp_reg[63:32] <= csr_wr_data[31:0];
            end

            // Trap entry owns mstatus/mepc/mcause in its cycle; otherwise software writes
            // win over mret for mstatus.
            if (in_enter) begin
                mepc_reg     <= retire_pc & ALIGN_MASK;
                mcause_reg   <= {1'b1, (XLEN-1)'(cause)};
                mpie_bit_reg <= mie_bit_reg;
                mie_bit_reg  <= 1'b0;
            end else begin
                if (wr_mepc) begin
                    mepc_reg <= csr_wr_data & ALIGN_MASK;
                end
                if (wr_mcause) begin
                    mcause_reg <= csr_wr_data;
                end
                if (wr_mstatus) begin
                    mie_bit_reg  <= csr_wr_data[3];
                    mpie_bit_reg <= csr_wr_data[7];
                end else if (mret_vld) begin
                    mie_bit_reg  <= mpie_bit_reg;
                    mpie_bit_reg <= 1'b1;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (take) begin
                        state_reg    <= ST_DRAIN;
                        hold_req_reg <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Losing the interrupt aborts the drain even if the pipeline just stopped.
                    if (!take) begin
                        state_reg    <= ST_IDLE;
                        hold_req_reg <= 1'b0;
                    end else if (hold_ack) begin
                        state_reg    <= ST_ENTER;
                        trap_vld_reg <= 1'b1;
                    end
                end
                ST_ENTER: begin
                    state_reg    <= ST_IDLE;
                    hold_req_reg <= 1'b0;
                    trap_vld_reg <= 1'b0;
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    hold_req_reg <= 1'b0;
                    trap_vld_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
